// File: rtl/host_bus_master_pkg.sv
// Shared constants for the 16-bit host register bus: cycle codes on {Sel, Rd_DS, Wr_RW}
// and the initiator state encoding, so initiator and responders agree on the same values.
package host_bus_master_pkg;

    localparam logic [2:0] IDLE_CYC = 3'b111;
    localparam logic [2:0] WR_CYC   = 3'b010;
    localparam logic [2:0] RD_CYC   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_t;

    function automatic logic [2:0] cycle_code(input logic write);
        return write ? WR_CYC : RD_CYC;
    endfunction

endpackage

// File: rtl/host_bus_master.sv
// Host register bus initiator: one valid/ready command becomes one bus read or write cycle
// and exactly one response pulse; unacknowledged cycles end in a timeout error response.
module host_bus_master
    import host_bus_master_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              BusMode,
    output logic [ADDR_W-1:0] Addr,
    output logic              Sel,
    output logic              Rd_DS,
    output logic              Wr_RW,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rdy_Dtack
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT > 0 ? RD_LAT - 1 : 0);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    bus_state_t  state;
    logic [2:0]  bus_code;
    logic        is_write;
    logic        acked;
    logic [2:0]  lat_cnt;
    logic [7:0]  to_cnt;

    assign BusMode = 1'b1;
    assign {Sel, Rd_DS, Wr_RW} = bus_code;

    // Once acked is set the cycle is committed: Rdy_Dtack is no longer looked at.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            Addr      <= '0;
            DataOut   <= '0;
            bus_code  <= IDLE_CYC;
            is_write  <= 1'b0;
            acked     <= 1'b0;
            lat_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        is_write  <= cmd_write;
                        Addr      <= cmd_addr;
                        DataOut   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bus_code <= cycle_code(is_write);
                    to_cnt   <= '0;
                    lat_cnt  <= '0;
                    acked    <= 1'b0;
                    state    <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (acked || !Rdy_Dtack) begin
                        if (is_write) begin
                            bus_code  <= IDLE_CYC;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                            state     <= ST_HOLD;
                        end else if (acked ? (lat_cnt == LAT_LAST) : (RD_LAT == 0)) begin
                            bus_code  <= IDLE_CYC;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= DataIn;
                            state     <= ST_HOLD;
                        end else begin
                            acked <= 1'b1;
                            if (acked) begin
                                lat_cnt <= lat_cnt + 3'd1;
                            end
                        end
                    end else if (to_cnt >= TO_LAST) begin
                        bus_code  <= IDLE_CYC;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= ST_HOLD;
                    end else if (to_cnt != 8'hFF) begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    bus_code <= IDLE_CYC;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/host_bus_master.md
# host_bus_master

Initiator for the 16-bit host register bus: it turns a single-command valid/ready request into a bus read or write cycle on BusMode, Addr, Sel, Rd_DS, Wr_RW and data, then returns one response per command. It sits between the control CPU-side logic and the forwarding lookup block (and any other bus responder) and supports table loading and readback. It tolerates both combinational and registered read data and reports unresponsive targets by timeout.

## Interface
Parameters:
- ADDR_W, 12, bus address width
- DATA_W, 16, bus data width
- RD_LAT, 1, cycles the strobe is held after the first acknowledge cycle of a read before data is sampled (0..7)
- TIMEOUT, 15, maximum strobe cycles without acknowledge before an error response (1..255)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  timeout flag, valid with rsp_valid
- BusMode  out  1  constant 1 after reset
- Addr  out  ADDR_W  bus address
- Sel  out  1  select, active low
- Rd_DS  out  1  read strobe, active low
- Wr_RW  out  1  write strobe, active low
- DataOut  out  DATA_W  write data to responder
- DataIn  in  DATA_W  read data from responder
- Rdy_Dtack  in  1  acknowledge, active low

## Operation
- Bus encoding {Sel, Rd_DS, Wr_RW}: idle 3'b111, write 3'b010, read 3'b001. No other codes are driven.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: cmd_ready = 1; on cmd_valid register write flag, address, and data, then go to SETUP. Strobes idle.
- SETUP (1 cycle): Addr/DataOut driven, strobes idle. Go to STROBE, clearing the timeout counter.
- STROBE: drive the read or write code. The first cycle with Rdy_Dtack = 0 is the ack cycle.
  - Write: on the ack cycle, go to HOLD.
  - Read: after the ack cycle, stay RD_LAT further cycles with the strobe held. Sample DataIn at the edge ending the last strobe cycle, then go to HOLD.
  - Once ack is seen, the cycle is committed. Later Rdy_Dtack changes are ignored.
  - If no ack after TIMEOUT strobe cycles, go to HOLD with rsp_err = 1 and rsp_rdata = 0.
- HOLD (1 cycle): strobes idle, Addr/DataOut held, rsp_valid = 1. Go to IDLE.
- Rdy_Dtack is ignored outside STROBE.
- cmd_* is ignored outside IDLE.
- Timeout counter width is 8 bits and saturates. It is never compared outside STROBE.

## Timing
- Reset values: cmd_ready 0 during reset and 1 from the first cycle after it; rsp_valid 0, rsp_err 0, rsp_rdata 0, Addr 0, DataOut 0, {Sel,Rd_DS,Wr_RW} 3'b111, BusMode 1; state IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from cmd_* or Rdy_Dtack to any output.
- Acceptance edge E0 leads to SETUP. E1 leads to STROBE. Ack sampled at E2 leads to HOLD, with rsp_valid high in the cycle after E2.
- Write, or read with RD_LAT = 0, against an immediate-ack responder: 4 cycles from acceptance to the next cmd_ready.
- Read with RD_LAT = n: n more cycles than a write.
- Timeout: rsp_valid is high in the cycle after the TIMEOUT-th strobe cycle.
- Back-to-back commands: the next acceptance happens no earlier than the IDLE cycle following HOLD, so at least one idle bus cycle always separates strobes.
- Reset mid-cycle: strobes return to idle at the reset edge and no response is issued for the aborted command.

## Structure
- A shared package/header holds the bus cycle codes (IDLE_CYC 3'b111, WR_CYC 3'b010, RD_CYC 3'b001) and the state encodings, so responders and this initiator use identical constants.
- One module, no sub-modules. The FSM and the timeout counter are inline.

## Test plan
- Write 0x00A5 to 0x012 with an immediate-ack responder: Wr_RW low for exactly 1 cycle with Addr = 0x012 and DataOut = 0x00A5; rsp_valid at acceptance+3 with rsp_err = 0.
- Read 0x034, RD_LAT = 1, responder data registered one cycle later (value 0x1234): Rd_DS low for 2 cycles; rsp_rdata = 0x1234.
- No responder (Rdy_Dtack stuck 1), TIMEOUT = 15: strobe low for 15 cycles, then rsp_err = 1 and rsp_rdata = 0; next command is accepted normally.
- cmd_valid held high for 3 writes to 0x000, 0x001, 0x002: three accepts, each separated by at least one idle bus cycle, and rsp_valid pulses in order.
- Reset asserted during a STROBE: the next cycle shows strobes 3'b111 and rsp_valid 0, with no response emitted afterwards.
- Spurious Rdy_Dtack = 0 in IDLE, and ack glitching high after the ack cycle of a read: neither has any effect; data is still sampled at the RD_LAT end.
